dmem_responder: RTL and testbench

//  Data-memory responder at the far end of the MEM-stage access issued from the EX/MEM register.

---
 rtl/dmem_responder.sv | 133 +++++++++++++
 tb/tb_dmem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Wait-state data memory for the MEM stage: byte/half/word loads and stores
// with a fixed access latency, stalling the pipeline until the access completes.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        ReadEnM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] load_data,
  output logic        stallM,
  output logic        misalignedM
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t        state, state_nx;
  logic [2:0]    cnt, cnt_nx;
  logic [AW+1:0] addr_q;
  logic [31:0]   data_q;
  logic [2:0]    f3_q;
  logic          store_q;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, legal, accept;
  logic [AW+1:0] acc_addr;
  logic [2:0]    acc_f3;
  logic          acc_store;
  logic [31:0]   acc_word;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^ALUResultM[31:AW+2];

  function automatic logic is_legal(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic ok;
    case (f3)
      3'b000:  ok = 1'b1;
      3'b001:  ok = ~a[0];
      3'b010:  ok = (a == 2'b00);
      3'b100:  ok = ~st;
      3'b101:  ok = ~st & ~a[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'b0, b};
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign req    = ReadEnM | MemWriteM;
  assign legal  = is_legal(MemWriteM, funct3M, ALUResultM[1:0]);
  assign accept = (state == IDLE) & req & legal;

  // In IDLE the access uses the live request; afterwards only the latched copy.
  assign acc_addr  = (state == IDLE) ? ALUResultM[AW+1:0] : addr_q;
  assign acc_f3    = (state == IDLE) ? funct3M : f3_q;
  assign acc_store = (state == IDLE) ? MemWriteM : store_q;
  assign acc_word  = mem[acc_addr[AW+1:2]];

  assign stallM      = accept | (state == WAIT);
  assign misalignedM = (state == IDLE) & req & ~legal;

  // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (accept) begin
        cnt_nx   = 3'(LATENCY);
        state_nx = (LATENCY == 0) ? DONE : WAIT;
      end
      WAIT: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      load_data <= 32'd0;
      store_q   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        addr_q  <= ALUResultM[AW+1:0];
        data_q  <= WriteDataM;
        f3_q    <= funct3M;
        store_q <= MemWriteM;
      end
      if (state_nx == DONE && !acc_store)
        load_data <= extract(acc_word, acc_f3, acc_addr[1:0]);
    end
  end

  // NOTE: the RAM array has no reset; contents survive clr and start undefined.
  always_ff @(posedge clk) begin
    if (!clr && state == DONE && store_q) begin
      case (f3_q[1:0])
        2'b00:   mem[addr_q[AW+1:2]][{addr_q[1:0], 3'b000} +: 8] <= data_q[7:0];
        2'b01:   mem[addr_q[AW+1:2]][{addr_q[1], 4'b0000} +: 16] <= data_q[15:0];
        default: mem[addr_q[AW+1:2]] <= data_q;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance,
// a byte-addressed transaction model checked every cycle, plus literal expectations.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        clr;
  logic        rd   [2];
  logic        wr   [2];
  logic [2:0]  f3   [2];
  logic [31:0] addr [2];
  logic [31:0] wd   [2];
  logic [31:0] ld   [2];
  logic        stall[2];
  logic        mis  [2];

  int tests  = 0;
  int failed = 0;
  bit check_en = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
    .clk(clk), .clr(clr), .ReadEnM(rd[0]), .MemWriteM(wr[0]), .funct3M(f3[0]),
    .ALUResultM(addr[0]), .WriteDataM(wd[0]), .load_data(ld[0]), .stallM(stall[0]),
    .misalignedM(mis[0]));

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(0)) dut1 (
    .clk(clk), .clr(clr), .ReadEnM(rd[1]), .MemWriteM(wr[1]), .funct3M(f3[1]),
    .ALUResultM(addr[1]), .WriteDataM(wd[1]), .load_data(ld[1]), .stallM(stall[1]),
    .misalignedM(mis[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  int          lat_m   [2] = '{2, 0};
  logic [7:0]  mem_b   [2][4096];
  bit          busy    [2] = '{0, 0};
  int          start   [2];
  bit          t_store [2];
  logic [2:0]  t_f3    [2];
  logic [31:0] t_addr  [2];
  logic [31:0] t_data  [2];
  logic [31:0] exp_ld  [2] = '{32'd0, 32'd0};
  int          cyc = 0;

  function automatic int m_size(input logic [2:0] f);
    case (f)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_legal(input bit st, input logic [2:0] f, input logic [31:0] a);
    int sz = m_size(f);
    if (sz == 0) return 0;
    if (st && f[2]) return 0;
    return (int'(a[11:0]) % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input int i, input logic [2:0] f, input logic [31:0] a);
    int sz = m_size(f);
    int base = int'(a[11:0]);
    logic [31:0] v = 32'd0;
    logic [31:0] mask;
    for (int k = 0; k < sz; k++) v = v | (32'(mem_b[i][base + k]) << (8 * k));
    if (sz < 4 && !f[2]) begin
      mask = (32'd1 << (8 * sz)) - 32'd1;
      if (v[8 * sz - 1]) v = v | ~mask;
    end
    return v;
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit rq, lg, e_stall, e_mis;
      int k;
      rq = rd[i] | wr[i];
      lg = m_legal(wr[i], f3[i], addr[i]);
      k  = cyc - start[i];
      if (busy[i]) begin
        e_stall = (k <= lat_m[i]);
        e_mis   = 0;
      end else begin
        e_stall = rq & lg;
        e_mis   = rq & ~lg;
      end
      if (check_en) begin
        check($sformatf("stall%0d@%0d", i, cyc), 32'(stall[i]), 32'(e_stall));
        check($sformatf("mis%0d@%0d", i, cyc), 32'(mis[i]), 32'(e_mis));
        check($sformatf("load_data%0d@%0d", i, cyc), ld[i], exp_ld[i]);
      end
      if (clr) begin
        busy[i]   = 0;
        exp_ld[i] = 32'd0;
      end else if (!busy[i]) begin
        if (rq && lg) begin
          busy[i]    = 1;
          start[i]   = cyc;
          t_store[i] = wr[i];
          t_f3[i]    = f3[i];
          t_addr[i]  = addr[i];
          t_data[i]  = wd[i];
          if (lat_m[i] == 0 && !wr[i]) exp_ld[i] = m_load(i, f3[i], addr[i]);
        end
      end else begin
        if (k == lat_m[i] && !t_store[i]) exp_ld[i] = m_load(i, t_f3[i], t_addr[i]);
        if (k == lat_m[i] + 1) begin
          if (t_store[i])
            for (int b = 0; b < m_size(t_f3[i]); b++)
              mem_b[i][int'(t_addr[i][11:0]) + b] = t_data[i][8 * b +: 8];
          busy[i] = 0;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  // Starts just after a rising edge; returns stall-cycle count, load_data in the first
  // non-stalled cycle, and misalignedM seen in the request cycle. Ends after the next edge.
  task automatic access(input int i, input bit st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] d, input bit chg, input logic [31:0] a2,
                        output int n, output logic [31:0] ld_o, output bit mis_o);
    rd[i] = !st; wr[i] = st; f3[i] = f; addr[i] = a; wd[i] = d;
    n = 0;
    @(negedge clk);
    mis_o = mis[i];
    while (stall[i] && n < 20) begin
      n++;
      if (chg && n == 1) begin
        @(posedge clk); #1 addr[i] = a2;
      end
      @(negedge clk);
    end
    ld_o = ld[i];
    @(posedge clk); #1;
    rd[i] = 0; wr[i] = 0;
  endtask

  int          n;
  logic [31:0] v;
  bit          m;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rd[i] = 0; wr[i] = 0; f3[i] = 3'd0; addr[i] = 32'd0; wd[i] = 32'd0;
    end
    clr = 1;
    repeat (2) @(posedge clk);
    #1 clr = 0;
    check_en = 1;
    @(negedge clk);
    check("reset_load_data", ld[0], 32'd0);
    check("reset_stall", 32'(stall[0]), 32'd0);
    check("reset_mis", 32'(mis[0]), 32'd0);
    @(posedge clk); #1;

    // 1: word store and load, LATENCY=2
    access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, n, v, m);
    check("sw_stall_cycles", 32'(n), 32'd3);
    access(0, 0, 3'b010, 32'h10, 0, 0, 0, n, v, m);
    check("lw_stall_cycles", 32'(n), 32'd3);
    check("lw_10", v, 32'hDEADBEEF);

    // 2: byte store into lane 3, then extensions
    access(0, 1, 3'b000, 32'h13, 32'h00000080, 0, 0, n, v, m);
    access(0, 0, 3'b000, 32'h13, 0, 0, 0, n, v, m);
    check("lb_13", v, 32'hFFFFFF80);
    access(0, 0, 3'b100, 32'h13, 0, 0, 0, n, v, m);
    check("lbu_13", v, 32'h00000080);
    access(0, 0, 3'b010, 32'h10, 0, 0, 0, n, v, m);
    check("lw_10_after_sb", v, 32'h80ADBEEF);
    access(0, 0, 3'b001, 32'h12, 0, 0, 0, n, v, m);
    check("lh_12", v, 32'hFFFF80AD);
    access(0, 0, 3'b101, 32'h12, 0, 0, 0, n, v, m);
    check("lhu_12", v, 32'h000080AD);

    // 3: illegal requests
    access(0, 1, 3'b001, 32'h11, 32'h0000FFFF, 0, 0, n, v, m);
    check("sh_11_mis", 32'(m), 32'd1);
    check("sh_11_stall", 32'(n), 32'd0);
    access(0, 0, 3'b010, 32'h10, 0, 0, 0, n, v, m);
    check("lw_10_unchanged", v, 32'h80ADBEEF);
    access(0, 0, 3'b011, 32'h10, 0, 0, 0, n, v, m);
    check("f3_011_mis", 32'(m), 32'd1);
    check("f3_011_ld_held", v, 32'h80ADBEEF);
    access(0, 1, 3'b100, 32'h10, 0, 0, 0, n, v, m);
    check("store_f3_100_mis", 32'(m), 32'd1);

    // 4: clr in the second WAIT cycle cancels the store
    access(0, 1, 3'b010, 32'h20, 32'h55AA33CC, 0, 0, n, v, m);
    rd[0] = 0; wr[0] = 1; f3[0] = 3'b010; addr[0] = 32'h20; wd[0] = 32'h12345678;
    @(posedge clk); #1;
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0; wr[0] = 0;
    @(negedge clk);
    check("clr_stall", 32'(stall[0]), 32'd0);
    check("clr_load_data", ld[0], 32'd0);
    @(posedge clk); #1;
    access(0, 0, 3'b010, 32'h20, 0, 0, 0, n, v, m);
    check("lw_20_prior", v, 32'h55AA33CC);

    // 5: back-to-back loads, address change mid-WAIT ignored
    access(0, 1, 3'b010, 32'h0, 32'h11111111, 0, 0, n, v, m);
    access(0, 1, 3'b010, 32'h4, 32'h22222222, 0, 0, n, v, m);
    access(0, 0, 3'b010, 32'h0, 0, 1, 32'h4, n, v, m);
    check("b2b_first_stall", 32'(n), 32'd3);
    check("b2b_first_data", v, 32'h11111111);
    access(0, 0, 3'b010, 32'h4, 0, 0, 0, n, v, m);
    check("b2b_second_stall", 32'(n), 32'd3);
    check("b2b_second_data", v, 32'h22222222);

    // 6: LATENCY=0 instance, address aliasing
    access(1, 1, 3'b010, 32'h0, 32'hCAFEF00D, 0, 0, n, v, m);
    check("lat0_sw_stall", 32'(n), 32'd1);
    access(1, 0, 3'b010, 32'h1000, 0, 0, 0, n, v, m);
    check("lat0_lw_stall", 32'(n), 32'd1);
    check("lat0_alias", v, 32'hCAFEF00D);
    access(1, 0, 3'b000, 32'h1003, 0, 0, 0, n, v, m);
    check("lat0_lb_alias", v, 32'hFFFFFFCA);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
